// File: rtl/park_keypad_entry.sv
// Keypad front end for the parking-gate password controller: debounced buttons,
// MSB-first code entry, submit strobe, failed-attempt counting and timed lockout.
module park_keypad_entry #(
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             front,
    input  logic                             btn0,
    input  logic                             btn1,
    input  logic                             btn_enter,
    input  logic                             btn_clear,
    input  logic                             pw_status_in,
    output logic [CODE_W-1:0]                password,
    output logic                             pw_valid,
    output logic [$clog2(CODE_W+1)-1:0]      bit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
    output logic                             locked,
    output logic                             granted
);
    localparam int unsigned BCW = $clog2(CODE_W + 1);
    localparam int unsigned FCW = $clog2(MAX_TRIES + 1);
    localparam int unsigned TW  = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned DCW = $clog2(DEBOUNCE + 1);
    localparam int unsigned NB  = 4;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE - 1);

    typedef enum logic [2:0] {StIdle, StEntry, StSubmit, StWait, StPassed, StLocked} state_e;

    // Button order: 0 = btn0, 1 = btn1, 2 = enter, 3 = clear
    logic [NB-1:0]          raw;
    logic [NB-1:0]          sync1_q, sync2_q, deb_q, press_q;
    logic [NB-1:0][DCW-1:0] deb_cnt_q;

    assign raw = {btn_clear, btn_enter, btn1, btn0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            press_q   <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NB; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_q[i]     <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                        press_q[i]   <= sync2_q[i];
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DCW'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    logic ev0, ev1, ev_enter, ev_clear, bit_ev, full;

    assign ev0      = press_q[0];
    assign ev1      = press_q[1];
    assign ev_enter = press_q[2];
    assign ev_clear = press_q[3];
    // Simultaneous 0 and 1 presses cancel each other
    assign bit_ev   = ev0 ^ ev1;
    assign full     = (bit_count == BCW'(CODE_W));

    state_e            state_q;
    logic [CODE_W-1:0] shift_q;
    logic [TW-1:0]     timer_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            timer_q    <= '0;
            password   <= '0;
            pw_valid   <= 1'b0;
            bit_count  <= '0;
            fail_count <= '0;
            locked     <= 1'b0;
            granted    <= 1'b0;
        end else begin
            pw_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (front) begin
                        state_q   <= StEntry;
                        shift_q   <= '0;
                        bit_count <= '0;
                    end
                end
                StEntry: begin
                    if (!front) begin
                        state_q   <= StIdle;
                        shift_q   <= '0;
                        bit_count <= '0;
                        password  <= '0;
                    end else if (ev_clear) begin
                        shift_q   <= '0;
                        bit_count <= '0;
                    end else if (ev_enter && full) begin
                        state_q  <= StSubmit;
                        password <= shift_q;
                        pw_valid <= 1'b1;
                    end else if (bit_ev && !full) begin
                        shift_q   <= {shift_q[CODE_W-2:0], ev1};
                        bit_count <= bit_count + BCW'(1);
                    end
                end
                StSubmit: begin
                    if (!front) begin
                        state_q   <= StIdle;
                        shift_q   <= '0;
                        bit_count <= '0;
                        password  <= '0;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!front) begin
                        state_q   <= StIdle;
                        shift_q   <= '0;
                        bit_count <= '0;
                        password  <= '0;
                    end else if (pw_status_in) begin
                        state_q    <= StPassed;
                        fail_count <= '0;
                        granted    <= 1'b1;
                    end else if (fail_count >= FCW'(MAX_TRIES - 1)) begin
                        state_q    <= StLocked;
                        fail_count <= FCW'(MAX_TRIES);
                        locked     <= 1'b1;
                        timer_q    <= TW'(LOCK_CYCLES);
                    end else begin
                        state_q    <= StEntry;
                        fail_count <= fail_count + FCW'(1);
                        shift_q    <= '0;
                        bit_count  <= '0;
                    end
                end
                StPassed: begin
                    if (!front) begin
                        state_q   <= StIdle;
                        granted   <= 1'b0;
                        shift_q   <= '0;
                        bit_count <= '0;
                        password  <= '0;
                    end
                end
                StLocked: begin
                    // Leaving on the last count keeps the dwell at exactly LOCK_CYCLES
                    if (timer_q == TW'(1)) begin
                        timer_q    <= '0;
                        locked     <= 1'b0;
                        fail_count <= '0;
                        shift_q    <= '0;
                        bit_count  <= '0;
                        if (front) begin
                            state_q <= StEntry;
                        end else begin
                            state_q  <= StIdle;
                            password <= '0;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_park_keypad_entry.sv
// Bench for park_keypad_entry: directed test-plan scenarios plus random button
// traffic, all outputs compared every cycle against a behavioural model.
module tb_park_keypad_entry;
    localparam int CODE_W      = 4;
    localparam int DEBOUNCE    = 3;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 20;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_SUBMIT = 2, M_WAIT = 3, M_PASSED = 4, M_LOCKED = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       front, btn0, btn1, btn_enter, btn_clear, pw_status_in;
    logic [3:0] password;
    logic       pw_valid;
    logic [2:0] bit_count;
    logic [1:0] fail_count;
    logic       locked, granted;

    park_keypad_entry #(
        .CODE_W(CODE_W), .DEBOUNCE(DEBOUNCE), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .front(front), .btn0(btn0), .btn1(btn1),
        .btn_enter(btn_enter), .btn_clear(btn_clear), .pw_status_in(pw_status_in),
        .password(password), .pw_valid(pw_valid), .bit_count(bit_count),
        .fail_count(fail_count), .locked(locked), .granted(granted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model
    logic [3:0] rh [0:7];
    logic [3:0] m_deb, m_ev;
    int m_st, m_code, m_bits, m_pw, m_valid, m_fail, m_lock_left, m_locked, m_granted;

    task automatic model_reset();
        for (int k = 0; k < 8; k++) rh[k] = '0;
        m_deb = '0; m_ev = '0;
        m_st = M_IDLE; m_code = 0; m_bits = 0; m_pw = 0; m_valid = 0;
        m_fail = 0; m_lock_left = 0; m_locked = 0; m_granted = 0;
    endtask

    task automatic model_go_idle();
        m_st = M_IDLE; m_bits = 0; m_code = 0; m_pw = 0; m_granted = 0;
    endtask

    task automatic model_step();
        bit e0, e1, ee, ec, diff;
        e0 = m_ev[0]; e1 = m_ev[1]; ee = m_ev[2]; ec = m_ev[3];
        m_valid = 0;
        case (m_st)
            M_IDLE: if (front) begin m_st = M_ENTRY; m_code = 0; m_bits = 0; end
            M_ENTRY: begin
                if (!front) model_go_idle();
                else if (ec) begin m_code = 0; m_bits = 0; end
                else if (ee && m_bits == CODE_W) begin m_st = M_SUBMIT; m_pw = m_code; m_valid = 1; end
                else if ((e0 != e1) && m_bits < CODE_W) begin
                    m_code = (m_code * 2 + int'(e1)) % (1 << CODE_W);
                    m_bits++;
                end
            end
            M_SUBMIT: if (!front) model_go_idle(); else m_st = M_WAIT;
            M_WAIT: begin
                if (!front) model_go_idle();
                else if (pw_status_in) begin m_st = M_PASSED; m_fail = 0; m_granted = 1; end
                else begin
                    m_fail = (m_fail + 1 > MAX_TRIES) ? MAX_TRIES : m_fail + 1;
                    if (m_fail == MAX_TRIES) begin
                        m_st = M_LOCKED; m_locked = 1; m_lock_left = LOCK_CYCLES;
                    end else begin
                        m_st = M_ENTRY; m_code = 0; m_bits = 0;
                    end
                end
            end
            M_PASSED: if (!front) model_go_idle();
            M_LOCKED: begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    m_locked = 0; m_fail = 0;
                    if (front) begin m_st = M_ENTRY; m_code = 0; m_bits = 0; end
                    else model_go_idle();
                end
            end
            default: m_st = M_IDLE;
        endcase
        // Raw history: the debouncer sees raw samples two edges old
        for (int k = 7; k > 0; k--) rh[k] = rh[k-1];
        rh[0] = {btn_clear, btn_enter, btn1, btn0};
        for (int i = 0; i < 4; i++) begin
            diff = 1'b1;
            for (int k = 2; k <= DEBOUNCE + 1; k++) if (rh[k][i] == m_deb[i]) diff = 1'b0;
            m_ev[i] = diff & ~m_deb[i];
            if (diff) m_deb[i] = ~m_deb[i];
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    int n_strobes = 0;
    int last_pw = -1;
    int n_lock_cyc = 0;

    always @(negedge clk) begin
        check("password", password, m_pw);
        check("pw_valid", pw_valid, m_valid);
        check("bit_count", bit_count, m_bits);
        check("fail_count", fail_count, m_fail);
        check("locked", locked, m_locked);
        check("granted", granted, m_granted);
        if (pw_valid === 1'b1) begin n_strobes++; last_pw = int'(password); end
        if (locked === 1'b1) n_lock_cyc++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn0 = v;
            1: btn1 = v;
            2: btn_enter = v;
            default: btn_clear = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        wait_cycles(8);
        set_btn(b, 1'b0);
        wait_cycles(DEBOUNCE + 5);
    endtask

    task automatic submit_code(input int code);
        for (int k = CODE_W - 1; k >= 0; k--) press((code >> k) & 1);
        press(2);
    endtask

    initial begin
        model_reset();
        reset = 1'b0; front = 0; btn0 = 0; btn1 = 0; btn_enter = 0; btn_clear = 0;
        pw_status_in = 0;
        wait_cycles(3);
        check("reset_outputs", {password, pw_valid, bit_count, fail_count, locked, granted}, 0);
        reset = 1'b1;
        wait_cycles(2);

        // Successful entry of 1010
        front = 1; pw_status_in = 1;
        wait_cycles(2);
        press(1); press(0); press(1); press(0);
        check("bits_1010", bit_count, 4);
        press(2);
        check("strobe_count", n_strobes, 1);
        check("strobe_code", last_pw, 4'b1010);
        check("granted_on", granted, 1);
        front = 0;
        wait_cycles(2);
        check("idle_password", password, 0);
        check("idle_granted", granted, 0);

        // Glitch rejection and event latency
        front = 1; pw_status_in = 0;
        wait_cycles(2);
        set_btn(1, 1'b1); wait_cycles(2); set_btn(1, 1'b0); wait_cycles(6);
        check("glitch_ignored", bit_count, 0);
        set_btn(1, 1'b1);
        wait_cycles(5);
        check("latency_early", bit_count, 0);
        wait_cycles(1);
        check("latency_event", bit_count, 1);
        wait_cycles(4); set_btn(1, 1'b0); wait_cycles(8);
        check("hold_one_event", bit_count, 1);

        // Short enter ignored, clear, overflow bit ignored
        press(0); press(1);
        press(2);
        check("short_enter", n_strobes, 1);
        press(3);
        check("clear", bit_count, 0);
        press(0); press(0); press(0); press(0); press(1);
        check("fifth_bit", bit_count, 4);
        press(2);
        check("fail_1", fail_count, 1);
        check("fail_code", last_pw, 0);
        submit_code(0);
        check("fail_2", fail_count, 2);
        n_lock_cyc = 0;
        submit_code(0);
        check("locked_on", locked, 1);
        press(1);
        wait_cycles(10);
        check("lock_dwell", n_lock_cyc, LOCK_CYCLES);
        check("unlock_fail", fail_count, 0);
        check("lock_press_ignored", bit_count, 0);

        // Simultaneous 0/1 events
        btn0 = 1; btn1 = 1; wait_cycles(8); btn0 = 0; btn1 = 0; wait_cycles(8);
        check("dual_bits", bit_count, 0);

        // Front drops during the result cycle
        submit_code(4'b0110);
        check("fail_again", fail_count, 1);
        for (int k = 3; k >= 0; k--) press((4'b1001 >> k) & 1);
        set_btn(2, 1'b1);
        begin
            int budget = 40;
            while (m_st != M_WAIT && budget > 0) begin wait_cycles(1); budget--; end
            check("reach_wait", budget > 0, 1);
        end
        front = 0;
        wait_cycles(2);
        check("drop_fail_kept", fail_count, 1);
        check("drop_password", password, 0);
        set_btn(2, 1'b0);
        wait_cycles(8);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) btn0 = ~btn0;
            if ($urandom_range(0, 9) == 0) btn1 = ~btn1;
            if ($urandom_range(0, 19) == 0) btn_enter = ~btn_enter;
            if ($urandom_range(0, 59) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 79) == 0) front = ~front;
            pw_status_in = ($urandom_range(0, 3) == 0);
            wait_cycles(1);
        end

        // Asynchronous reset in the middle of a lockout
        btn0 = 0; btn1 = 0; btn_enter = 0; btn_clear = 0; front = 0;
        reset = 1'b0; wait_cycles(2); reset = 1'b1;
        front = 1; pw_status_in = 0;
        wait_cycles(2);
        submit_code(4'hf); submit_code(4'hf); submit_code(4'hf);
        wait_cycles(3);
        check("pre_reset_locked", locked, 1);
        check("pre_reset_pw", password, 4'hf);
        #2;
        reset = 1'b0;
        #1;
        check("async_locked", locked, 0);
        check("async_fail", fail_count, 0);
        check("async_password", password, 0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
